// File: rtl/pong_score.sv
// pong_score: edge-detected point/start events drive BCD scores, post-point hold timer and match-over state
module pong_score #(
  parameter int WIN_SCORE   = 5,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1_point,
  input  logic       p2_point,
  input  logic       start,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       play,
  output logic       game_over,
  output logic       winner
);
  localparam int TW = $clog2(HOLD_CYCLES + 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [TW-1:0] HLOAD = TW'(HOLD_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PLAY, HOLD, OVER} state_t;
  state_t state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [3:0] dig1_n, dig0_n;
  logic winner_n, p1_prev, p2_prev, start_prev;
  logic p1_ev, p2_ev, start_ev;
  assign p1_ev = p1_point & ~p1_prev;
  assign p2_ev = p2_point & ~p2_prev;
  assign start_ev = start & ~start_prev;
  assign play = state == PLAY;
  assign game_over = state == OVER;
  always_comb begin
    state_n = state;
    tmr_n = tmr;
    dig1_n = dig1;
    dig0_n = dig0;
    winner_n = winner;
    case (state)
      IDLE: state_n = start_ev ? PLAY : IDLE;
      PLAY:
        if (p1_ev ^ p2_ev) begin
          dig1_n = p1_ev ? dig1 + 4'd1 : dig1;
          dig0_n = p2_ev ? dig0 + 4'd1 : dig0;
          if ((p1_ev ? dig1_n : dig0_n) == WIN) begin
            state_n = OVER;
            winner_n = p2_ev;
          end else begin
            state_n = HOLD;
            tmr_n = HLOAD;
          end
        end
      HOLD: begin
        state_n = tmr == '0 ? PLAY : HOLD;
        tmr_n = tmr - TW'(1);
      end
      OVER:
        if (start_ev) begin
          state_n = PLAY;
          dig1_n = '0;
          dig0_n = '0;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tmr <= '0;
      dig1 <= '0;
      dig0 <= '0;
      winner <= 1'b0;
      p1_prev <= 1'b0;
      p2_prev <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      state <= state_n;
      tmr <= tmr_n;
      dig1 <= dig1_n;
      dig0 <= dig0_n;
      winner <= winner_n;
      p1_prev <= p1_point;
      p2_prev <= p2_point;
      start_prev <= start;
    end
  end
endmodule

// File: tb/tb_pong_score.sv
// tb_pong_score: directed bench for pong_score with WIN_SCORE=3, HOLD_CYCLES=4
module tb_pong_score;
  logic clk = 1'b0, reset = 1'b0, p1_point = 1'b0, p2_point = 1'b0, start = 1'b0;
  logic [3:0] dig1, dig0;
  logic play, game_over, winner;
  int errors = 0, checks = 0;
  pong_score #(.WIN_SCORE(3), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .p1_point(p1_point), .p2_point(p2_point), .start(start),
    .dig1(dig1), .dig0(dig0), .play(play), .game_over(game_over), .winner(winner)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic score(input bit p2);
    p1_point = !p2;
    p2_point = p2;
    step(1);
    p1_point = 1'b0;
    p2_point = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    chk("rst_dig1", dig1, 0);
    chk("rst_dig0", dig0, 0);
    chk("rst_play", {3'b0, play}, 0);
    chk("rst_over", {3'b0, game_over}, 0);
    chk("rst_winner", {3'b0, winner}, 0);
    step(2);
    chk("idle_play", {3'b0, play}, 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("start_play", {3'b0, play}, 1);
    chk("start_dig1", dig1, 0);
    chk("start_over", {3'b0, game_over}, 0);
    p1_point = 1'b1;
    step(1);
    chk("pt1_dig1", dig1, 1);
    chk("hold_c1", {3'b0, play}, 0);
    p2_point = 1'b1;
    step(1);
    p2_point = 1'b0;
    chk("hold_c2", {3'b0, play}, 0);
    step(1);
    chk("hold_c3", {3'b0, play}, 0);
    step(1);
    chk("hold_c4", {3'b0, play}, 0);
    step(1);
    chk("hold_end", {3'b0, play}, 1);
    chk("hold_p2_ign", dig0, 0);
    step(5);
    p1_point = 1'b0;
    chk("held_once", dig1, 1);
    chk("held_play", {3'b0, play}, 1);
    step(1);
    p1_point = 1'b1;
    p2_point = 1'b1;
    step(1);
    p1_point = 1'b0;
    p2_point = 1'b0;
    chk("both_dig1", dig1, 1);
    chk("both_dig0", dig0, 0);
    chk("both_play", {3'b0, play}, 1);
    step(1);
    score(1'b1);
    chk("s_dig0_1", dig0, 1);
    step(4);
    chk("s_play1", {3'b0, play}, 1);
    score(1'b0);
    chk("s_dig1_2", dig1, 2);
    step(4);
    score(1'b1);
    chk("s_dig0_2", dig0, 2);
    step(4);
    score(1'b1);
    chk("win_dig0", dig0, 3);
    chk("win_dig1", dig1, 2);
    chk("win_over", {3'b0, game_over}, 1);
    chk("win_winner", {3'b0, winner}, 1);
    chk("win_play", {3'b0, play}, 0);
    step(1);
    score(1'b0);
    step(2);
    score(1'b1);
    step(2);
    chk("over_dig1", dig1, 2);
    chk("over_dig0", dig0, 3);
    chk("over_stay", {3'b0, game_over}, 1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("rs_dig0", dig0, 0);
    chk("rs_dig1", dig1, 0);
    chk("rs_over", {3'b0, game_over}, 0);
    chk("rs_play", {3'b0, play}, 1);
    step(1);
    chk("rs_nohold", {3'b0, play}, 1);
    score(1'b0);
    step(4);
    score(1'b0);
    chk("h_dig1_2", dig1, 2);
    step(1);
    chk("h_mid", {3'b0, play}, 0);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mr_dig1", dig1, 0);
    chk("mr_dig0", dig0, 0);
    chk("mr_play", {3'b0, play}, 0);
    chk("mr_over", {3'b0, game_over}, 0);
    chk("mr_winner", {3'b0, winner}, 0);
    score(1'b0);
    step(6);
    chk("idle_pt_dig1", dig1, 0);
    chk("idle_pt_play", {3'b0, play}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
